// File: rtl/sample_trigger.sv
// sample_trigger: trigger and capture-window controller for the decimated
// sample stream in the core_clk domain. Sequences a pre-trigger fill, arms a
// per-bit level/edge trigger, counts the post-trigger window, forwards only
// in-window samples and reports the trigger index within the capture.
//
// Build option: define EXT_TRIG_EN to let a rising edge on ext_trig_in
// (synchronised into core_clk) force a trigger on the next valid sample while
// ARMED. Without it ext_trig_in is ignored.
module sample_trigger #(
    parameter int CNT_W = 32
) (
    input  logic             core_clk,
    input  logic             core_rst,
    input  logic             capture_start,
    input  logic             capture_abort,
    input  logic [CNT_W-1:0] pre_depth,
    input  logic [CNT_W-1:0] post_depth,
    input  logic [15:0]      trig_mask,
    input  logic [15:0]      trig_value,
    input  logic [15:0]      trig_edge,
    input  logic [15:0]      sample_data,
    input  logic             sample_valid,
    input  logic             ext_trig_in,
    output logic [15:0]      out_data,
    output logic             out_valid,
    output logic             trig_hit,
    output logic [CNT_W-1:0] trig_pos,
    output logic             capture_busy,
    output logic             capture_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;   // index of the next sample within the capture
    logic [CNT_W-1:0] post_cnt;     // post samples seen, trigger sample inclusive
    logic [CNT_W-1:0] pre_len;      // pre_depth captured at start
    logic [CNT_W-1:0] post_len;     // post_depth captured at start, 0 promoted to 1
    logic [15:0]      prev_data;
    logic             prev_ok;
    logic             ext_pend;

    logic             busy_state;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] post_inc;
    logic [15:0]      lvl_ok;
    logic [15:0]      edge_ok;
    logic [15:0]      bit_ok;
    logic             pattern_match;
    logic             trig_fire;

    assign busy_state = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);

    // The sample counter saturates rather than wrapping so trig_pos never aliases.
    assign cnt_inc  = (sample_cnt == {CNT_W{1'b1}}) ? sample_cnt : sample_cnt + CNT_ONE;
    assign post_inc = post_cnt + CNT_ONE;

    // Per-bit trigger terms: unmasked bits must match level, or match level
    // after a change from the previous valid sample when marked as edge bits.
    assign lvl_ok        = ~(sample_data ^ trig_value);
    assign edge_ok       = lvl_ok & (sample_data ^ prev_data) & {16{prev_ok}};
    assign bit_ok        = ~trig_mask | (trig_edge & edge_ok) | (~trig_edge & lvl_ok);
    assign pattern_match = &bit_ok;

    // Trigger qualifier: only valid samples in ARMED may fire.
    always_comb begin
        // NOTE: a default assignment first keeps every path covered so no latch is inferred.
        trig_fire = 1'b0;
        if (sample_valid && (state == ST_ARMED)) begin
            trig_fire = pattern_match || ext_pend;
        end
    end

`ifdef EXT_TRIG_EN
    logic ext_s1;
    logic ext_s2;
    logic ext_s3;
    logic ext_rise;

    assign ext_rise = ext_s2 & ~ext_s3;

    // Two-flop synchroniser, edge detect and pending latch for the external trigger.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            ext_s1   <= 1'b0;
            ext_s2   <= 1'b0;
            ext_s3   <= 1'b0;
            ext_pend <= 1'b0;
        end else begin
            ext_s1 <= ext_trig_in;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
            if (capture_start || capture_abort || trig_fire) begin
                ext_pend <= 1'b0;
            end else if ((state == ST_ARMED) && ext_rise) begin
                ext_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_ext_trig;

    assign unused_ext_trig = ext_trig_in;
    assign ext_pend        = 1'b0;
`endif

    // Capture FSM with registered status, trigger and forwarding outputs.
    always_ff @(posedge core_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (core_rst) begin
            state        <= ST_IDLE;
            sample_cnt   <= '0;
            post_cnt     <= '0;
            pre_len      <= '0;
            post_len     <= '0;
            prev_data    <= '0;
            prev_ok      <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            trig_hit     <= 1'b0;
            trig_pos     <= '0;
            capture_busy <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            trig_hit <= 1'b0;

            // A sample coinciding with start/abort belongs to no capture window.
            out_valid <= sample_valid && busy_state && !capture_start && !capture_abort;
            if (sample_valid && busy_state) begin
                out_data <= sample_data;
            end

            if (capture_start) begin
                sample_cnt   <= '0;
                post_cnt     <= '0;
                prev_ok      <= 1'b0;
                trig_pos     <= '0;
                pre_len      <= pre_depth;
                post_len     <= (post_depth == '0) ? CNT_ONE : post_depth;
                state        <= (pre_depth != '0) ? ST_PRE : ST_ARMED;
                capture_busy <= 1'b1;
                capture_done <= 1'b0;
            end else if (capture_abort) begin
                state        <= ST_IDLE;
                capture_busy <= 1'b0;
                capture_done <= 1'b0;
            end else if (sample_valid && busy_state) begin
                sample_cnt <= cnt_inc;
                prev_data  <= sample_data;
                prev_ok    <= 1'b1;
                case (state)
                    ST_PRE: begin
                        if (cnt_inc >= pre_len) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_fire) begin
                            trig_hit <= 1'b1;
                            trig_pos <= sample_cnt;
                            post_cnt <= CNT_ONE;
                            if (post_len <= CNT_ONE) begin
                                state        <= ST_DONE;
                                capture_busy <= 1'b0;
                                capture_done <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post_cnt <= post_inc;
                        if (post_inc >= post_len) begin
                            state        <= ST_DONE;
                            capture_busy <= 1'b0;
                            capture_done <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
